// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MUL   = 3'd4
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_WAIT,
        ST_DIV_WAIT,
        ST_HOLD
    } muldiv_state_t;

    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MUL);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_signfix.sv
// Sign correction around the unsigned Mul/Div units: operand magnitudes on the
// accept path, product and quotient/remainder negation on the completion path.
module muldiv_ctrl_signfix (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        neg_a_i,
    input  logic        neg_b_i,
    output logic [31:0] a_abs_o,
    output logic [31:0] b_abs_o,
    input  logic [63:0] prod_i,
    input  logic        neg_prod_i,
    output logic [63:0] prod_o,
    input  logic [31:0] quot_i,
    input  logic [31:0] rem_i,
    input  logic        neg_quot_i,
    input  logic        neg_rem_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    always_comb begin
        a_abs_o = neg_a_i    ? (~a_i + 32'd1)    : a_i;
        b_abs_o = neg_b_i    ? (~b_i + 32'd1)    : b_i;
        prod_o  = neg_prod_i ? (~prod_i + 64'd1) : prod_i;
        quot_o  = neg_quot_i ? (~quot_i + 32'd1) : quot_i;
        rem_o   = neg_rem_i  ? (~rem_i + 32'd1)  : rem_i;
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencing controller: accepts one E-stage request, drives the
// unsigned Mul/Div units, sign-corrects the result and holds it until adv.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int DIVZ_SHORTCUT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic        adv,
    output logic        stall,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        hi_we,
    output logic        lo_we,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c,
    output logic        div_valid,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [63:0] div_c
);

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_q, op_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic [31:0]   a_mag_q, a_mag_d;
    logic [31:0]   b_mag_q, b_mag_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [31:0]   res_lo_q, res_lo_d;
    logic          hi_we_q, hi_we_d;
    logic          lo_we_q, lo_we_d;

    logic          accept;
    logic          req_sgn;
    logic [31:0]   a_abs, b_abs;
    logic [63:0]   prod_fix;
    logic [31:0]   quot_fix, rem_fix;

    assign req_sgn = op_signed(req_op);
    assign accept  = (state_q == ST_IDLE) && req_valid && op_legal(req_op) && !flush;

    // Request operands and unit results never need correcting in the same
    // cycle, so one sign-fix block serves both paths.
    muldiv_ctrl_signfix u_signfix (
        .a_i        (req_a),
        .b_i        (req_b),
        .neg_a_i    (req_sgn & req_a[31]),
        .neg_b_i    (req_sgn & req_b[31]),
        .a_abs_o    (a_abs),
        .b_abs_o    (b_abs),
        .prod_i     (mul_c),
        .neg_prod_i (sign_a_q ^ sign_b_q),
        .prod_o     (prod_fix),
        .quot_i     (div_c[31:0]),
        .rem_i      (div_c[63:32]),
        .neg_quot_i (sign_a_q ^ sign_b_q),
        .neg_rem_i  (sign_a_q),
        .quot_o     (quot_fix),
        .rem_o      (rem_fix)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_we_d  = hi_we_q;
        lo_we_d  = lo_we_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = muldiv_op_t'(req_op);
                    sign_a_d = req_sgn & req_a[31];
                    sign_b_d = req_sgn & req_b[31];
                    a_mag_d  = a_abs;
                    b_mag_d  = b_abs;
                    if (op_is_div(req_op)) begin
                        if ((DIVZ_SHORTCUT != 0) && (req_b == '0)) begin
                            state_d  = ST_HOLD;
                            res_hi_d = req_a;
                            res_lo_d = DIVZ_LO;
                            hi_we_d  = 1'b1;
                            lo_we_d  = 1'b1;
                        end else begin
                            state_d = ST_DIV_WAIT;
                        end
                    end else begin
                        state_d = ST_MUL_WAIT;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    state_d  = ST_HOLD;
                    res_hi_d = prod_fix[63:32];
                    res_lo_d = prod_fix[31:0];
                    hi_we_d  = (op_q != OP_MUL);
                    lo_we_d  = (op_q != OP_MUL);
                end
            end
            ST_DIV_WAIT: begin
                if (div_done) begin
                    state_d  = ST_HOLD;
                    res_hi_d = rem_fix;
                    res_lo_d = quot_fix;
                    hi_we_d  = 1'b1;
                    lo_we_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (adv) begin
                    state_d = ST_IDLE;
                    hi_we_d = 1'b0;
                    lo_we_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d = ST_IDLE;
            hi_we_d = 1'b0;
            lo_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_we_q  <= 1'b0;
            lo_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_we_q  <= hi_we_d;
            lo_we_q  <= lo_we_d;
        end
    end

    always_comb begin
        busy      = (state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT);
        stall     = accept || busy;
        res_valid = (state_q == ST_HOLD);
        res_hi    = res_hi_q;
        res_lo    = res_lo_q;
        hi_we     = hi_we_q;
        lo_we     = lo_we_q;
        mul_valid = (state_q == ST_MUL_WAIT);
        div_valid = (state_q == ST_DIV_WAIT);
        mul_a     = a_mag_q;
        mul_b     = b_mag_q;
        div_a     = a_mag_q;
        div_b     = b_mag_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl; the bench plays the Mul/Div units itself.
module tb_muldiv_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush, adv;
    logic        stall, busy, res_valid, hi_we, lo_we;
    logic [31:0] res_hi, res_lo;
    logic        mul_valid, div_valid;
    logic [31:0] mul_a, mul_b, div_a, div_b;
    logic        mul_done, div_done;
    logic [63:0] mul_c, div_c;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        we;
        logic        chk_hi;
        logic [31:0] ma;
        logic [31:0] mb;
        logic        divz;
    } exp_t;

    exp_t sb[$];

    muldiv_ctrl #(.DIVZ_SHORTCUT(1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .flush(flush), .adv(adv),
        .stall(stall), .busy(busy), .res_valid(res_valid),
        .res_hi(res_hi), .res_lo(res_lo), .hi_we(hi_we), .lo_we(lo_we),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c),
        .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic sgn;
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb_;
        sgn = (op == 3'd0) || (op == 3'd2) || (op == 3'd4);
        e.ma = (sgn && a[31]) ? -a : a;
        e.mb = (sgn && b[31]) ? -b : b;
        e.chk_hi = 1'b1;
        e.we = 1'b1;
        e.divz = 1'b0;
        sa = a;
        sb_ = b;
        case (op)
            3'd0, 3'd4: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = sp;
                if (op == 3'd4) begin
                    e.chk_hi = 1'b0;
                    e.we = 1'b0;
                end
            end
            3'd1: {e.hi, e.lo} = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) begin
                    e.divz = 1'b1;
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    e.lo = sa / sb_;
                    e.hi = sa % sb_;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Full transaction: accept, unit handshake with given latency, HOLD for
    // hold_cycles with adv low, then adv. Ends one cycle into IDLE.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int hold_cycles);
        exp_t e;
        logic is_div;
        is_div = (op == 3'd2) || (op == 3'd3);
        sb.push_back(model(op, a, b));
        e = sb[$];
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_stall op=%0d: stall=%b want 1", op, stall);
        end
        step();
        if (!e.divz) begin
            for (int c = 0; c < lat; c++) begin
                tests_run++;
                if ({mul_valid, div_valid, stall, busy} !== {!is_div, is_div, 2'b11} ||
                    (is_div ? {div_a, div_b} : {mul_a, mul_b}) !== {e.ma, e.mb}) begin
                    tests_failed++;
                    $display("FAIL wait op=%0d cyc=%0d: mv=%b dv=%b st=%b bz=%b a=%h b=%h want mv=%b dv=%b a=%h b=%h",
                             op, c, mul_valid, div_valid, stall, busy,
                             is_div ? div_a : mul_a, is_div ? div_b : mul_b, !is_div, is_div, e.ma, e.mb);
                end
                if (c == lat - 1) begin
                    if (is_div) begin
                        div_done = 1'b1;
                        div_c = {e.ma % e.mb, e.ma / e.mb};
                    end else begin
                        mul_done = 1'b1;
                        mul_c = {32'd0, e.ma} * {32'd0, e.mb};
                    end
                end else if (c == 0) begin
                    // the other unit's done must not complete this op
                    if (is_div) mul_done = 1'b1; else div_done = 1'b1;
                    mul_c = '1; div_c = '1;
                end
                step();
                mul_done = 1'b0; div_done = 1'b0;
            end
        end else begin
            tests_run++;
            if ({div_valid, mul_valid, busy} !== 3'b000) begin
                tests_failed++;
                $display("FAIL divz_no_issue: dv=%b mv=%b busy=%b want 000", div_valid, mul_valid, busy);
            end
        end
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_empty op=%0d", op);
        end else begin
            e = sb.pop_front();
            for (int h = 0; h <= hold_cycles; h++) begin
                tests_run++;
                if ({res_valid, stall, busy, mul_valid, div_valid} !== 5'b10000 ||
                    res_lo !== e.lo || (e.chk_hi && res_hi !== e.hi) ||
                    hi_we !== e.we || lo_we !== e.we) begin
                    tests_failed++;
                    $display("FAIL hold op=%0d a=%h b=%h h=%0d: rv=%b st=%b bz=%b hi=%h lo=%h hwe=%b lwe=%b want hi=%h lo=%h we=%b",
                             op, a, b, h, res_valid, stall, busy, res_hi, res_lo, hi_we, lo_we, e.hi, e.lo, e.we);
                end
                if (h < hold_cycles) step();
            end
        end
        adv = 1'b1;
        req_valid = 1'b0;
        step();
        adv = 1'b0;
        tests_run++;
        if ({res_valid, hi_we, lo_we, stall, busy} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL release op=%0d: rv=%b hwe=%b lwe=%b st=%b bz=%b want 00000",
                     op, res_valid, hi_we, lo_we, stall, busy);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        #1;
        tests_run++;
        if ({stall, busy, res_valid, hi_we, lo_we, mul_valid, div_valid} !== 7'd0 ||
            {res_hi, res_lo, mul_a, mul_b, div_a, div_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: st=%b bz=%b rv=%b hi=%h lo=%h mv=%b dv=%b ma=%h want all 0",
                     stall, busy, res_valid, res_hi, res_lo, mul_valid, div_valid, mul_a);
        end
    endtask

    task automatic test_mult();
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 3, 0);
        do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 2, 0);
    endtask

    task automatic test_div();
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 2, 0);
        do_op(3'd3, 32'd7, 32'd2, 1, 0);
        do_op(3'd2, 32'd100, 32'hFFFF_FFF9, 3, 0);
    endtask

    task automatic test_divz();
        do_op(3'd3, 32'd7, 32'd0, 1, 0);
        do_op(3'd2, 32'hFFFF_FFF0, 32'd0, 1, 0);
    endtask

    task automatic test_flush();
        req_valid = 1'b1; req_op = 3'd2; req_a = 32'd100; req_b = 32'd3;
        step();
        step();
        flush = 1'b1;
        div_done = 1'b1;
        div_c = {32'd1, 32'd33};
        req_valid = 1'b0;
        step();
        flush = 1'b0;
        div_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({div_valid, busy, res_valid, hi_we, lo_we} !== 5'b00000) begin
                tests_failed++;
                $display("FAIL flush cyc=%0d: dv=%b bz=%b rv=%b hwe=%b lwe=%b want 00000",
                         i, div_valid, busy, res_valid, hi_we, lo_we);
            end
            step();
        end
        // flush outranks accept in IDLE
        req_valid = 1'b1; req_op = 3'd0; flush = 1'b1;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_accept: stall=%b want 0", stall);
        end
        step();
        flush = 1'b0; req_valid = 1'b0;
        tests_run++;
        if ({busy, mul_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_accept_state: busy=%b mv=%b want 00", busy, mul_valid);
        end
    endtask

    task automatic test_hold();
        do_op(3'd4, 32'h0001_0000, 32'h0001_0000, 2, 3);
        do_op(3'd4, 32'hFFFF_FFFE, 32'd3, 1, 1);
    endtask

    task automatic test_illegal();
        for (int op = 5; op < 8; op++) begin
            req_valid = 1'b1; req_op = 3'(op); req_a = 32'd9; req_b = 32'd3;
            #1;
            tests_run++;
            if (stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL illegal_stall op=%0d: stall=%b want 0", op, stall);
            end
            step();
            tests_run++;
            if ({busy, mul_valid, div_valid, res_valid} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL illegal_state op=%0d: bz=%b mv=%b dv=%b rv=%b want 0000",
                         op, busy, mul_valid, div_valid, res_valid);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd6; req_b = 32'd7;
        step();
        req_valid = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        tests_run++;
        if ({stall, busy, res_valid, hi_we, lo_we, mul_valid, div_valid} !== 7'd0 ||
            {mul_a, mul_b, res_hi, res_lo} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: st=%b bz=%b rv=%b mv=%b ma=%h mb=%h want all 0",
                     stall, busy, res_valid, mul_valid, mul_a, mul_b);
        end
        mul_done = 1'b1; mul_c = 64'd42;
        step();
        mul_done = 1'b0;
        step();
        tests_run++;
        if ({res_valid, busy, res_lo} !== {2'b00, 32'd0}) begin
            tests_failed++;
            $display("FAIL stray_done: rv=%b bz=%b lo=%h want 0 0 0", res_valid, busy, res_lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(0, 4));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) a = a | 32'h8000_0000;
            if (i % 3 == 2) b = b | 32'h8000_0000;
            if ((op == 3'd2) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) b = 32'd1;
            do_op(op, a, b, $urandom_range(1, 4), $urandom_range(0, 2));
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        resetn = 1'b0;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        flush = 1'b0; adv = 1'b0;
        mul_done = 1'b0; div_done = 1'b0; mul_c = '0; div_c = '0;
        test_reset();
        test_mult();
        test_div();
        test_divz();
        test_flush();
        test_hold();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
